// File: rtl/qam_demodulation.sv
// rtl/qam_demodulation.sv - Hard-decision QAM-4 demapper with Avalon-ST framing checks
//
// Purpose: slices PIPELINE_DEEPTH signed I/Q pairs per beat into 2-bit symbols
//          (sym[1] = Q sign, sym[0] = I sign, zero counts as positive) through one
//          registered stage with ready/valid backpressure, a packet-framing FSM and
//          status counters.
// Optional: QAM_DEMOD_WEAK_CNT_EN adds status_weak_count (per-packet count of
//           components with |value| < WEAK_THRESH, saturating at 0xFFFF).
// Ports:
//   clock_clk, reset_reset           clock, asynchronous active-high reset
//   asi_in0_*                        sample sink (data/valid/ready/sop/eop)
//   aso_out0_*                       symbol source (data/valid/ready/sop/eop)
//   status_pkt_count                 completed packets, wraps
//   status_error                     sticky framing error
//   status_weak_count                (optional) weak components of last packet

module qam_demodulation #(
    parameter int QAM_STAGE       = 4,
    parameter int MOD_OUT_WIDTH   = 8,
    parameter int PIPELINE_DEEPTH = 16,
    parameter int WEAK_THRESH     = 2**MOD_OUT_WIDTH/8
) (
    input  logic                                     clock_clk,
    input  logic                                     reset_reset,
    input  logic [PIPELINE_DEEPTH*MOD_OUT_WIDTH*2-1:0] asi_in0_data,
    input  logic                                     asi_in0_valid,
    output logic                                     asi_in0_ready,
    input  logic                                     asi_in0_startofpacket,
    input  logic                                     asi_in0_endofpacket,
    output logic [PIPELINE_DEEPTH*2-1:0]             aso_out0_data,
    output logic                                     aso_out0_valid,
    input  logic                                     aso_out0_ready,
    output logic                                     aso_out0_startofpacket,
    output logic                                     aso_out0_endofpacket,
    output logic [31:0]                              status_pkt_count,
    output logic                                     status_error
`ifdef QAM_DEMOD_WEAK_CNT_EN
    ,
    output logic [15:0]                              status_weak_count
`endif
);

    localparam int W     = MOD_OUT_WIDTH;
    localparam int PD    = PIPELINE_DEEPTH;
    localparam int IN_W  = PD * 2 * W;
    localparam int OUT_W = PD * 2;

    if (QAM_STAGE != 4 || WEAK_THRESH < 0) begin : g_bad_cfg
        $error("qam_demodulation: only QAM_STAGE=4 with non-negative WEAK_THRESH is supported");
    end

    typedef enum logic {ST_IDLE, ST_IN_PKT} state_t;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_sop_q, out_sop_d;
    logic               out_eop_q, out_eop_d;
    logic [31:0]        pkt_count_q, pkt_count_d;
    logic               error_q, error_d;

    logic               in_ready;
    logic               accept;
    logic               fwd;
    logic [OUT_W-1:0]   syms;

    // Only the sign bits feed the slicer; the rest of each sample is
    // deliberately ignored in the default build.
    logic               data_unused;
    assign data_unused = ^asi_in0_data;

    always_comb begin
        syms = '0;
        for (int i = 0; i < PD; i++) begin
            syms[OUT_W-1-2*i -: 2] = {asi_in0_data[IN_W-1-i*2*W-W],
                                      asi_in0_data[IN_W-1-i*2*W]};
        end
    end

    always_comb begin
        in_ready = !out_valid_q || aso_out0_ready;
        accept   = asi_in0_valid && in_ready;
        // A beat without SOP outside a packet is consumed but never forwarded.
        fwd      = accept && !(state_q == ST_IDLE && !asi_in0_startofpacket);

        state_d     = state_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        pkt_count_d = pkt_count_q;
        error_d     = error_q;

        // An accept implies the output register is empty or being drained,
        // so a dropped beat simply leaves it empty.
        out_valid_d = accept ? fwd : (out_valid_q && !aso_out0_ready);

        if (fwd) begin
            out_data_d = syms;
            out_sop_d  = asi_in0_startofpacket;
            out_eop_d  = asi_in0_endofpacket;
            if (asi_in0_endofpacket) begin
                state_d     = ST_IDLE;
                pkt_count_d = pkt_count_q + 32'd1;
            end else begin
                state_d = ST_IN_PKT;
            end
        end

        if (accept && ((state_q == ST_IDLE && !asi_in0_startofpacket) ||
                       (state_q == ST_IN_PKT && asi_in0_startofpacket))) begin
            error_d = 1'b1;
        end
    end

`ifdef QAM_DEMOD_WEAK_CNT_EN
    localparam int          CW       = $clog2(2*PD + 1);
    localparam logic [W:0]  THRESH_V = WEAK_THRESH[W:0];

    logic [15:0]   weak_acc_q, weak_acc_d;
    logic [15:0]   weak_out_q, weak_out_d;
    logic [CW-1:0] weak_beat;
    logic [16:0]   weak_sum;
    logic [15:0]   weak_next;

    // Magnitude is taken in W+1 bits so the most negative sample maps to 2**(W-1).
    function automatic logic is_weak(input logic [W-1:0] c);
        logic [W:0] ext;
        logic [W:0] mag;
        ext = {c[W-1], c};
        mag = ext[W] ? (~ext + 1'b1) : ext;
        return mag < THRESH_V;
    endfunction

    always_comb begin
        weak_beat = '0;
        for (int i = 0; i < PD; i++) begin
            weak_beat = weak_beat
                      + CW'(is_weak(asi_in0_data[IN_W-1-i*2*W -: W]))
                      + CW'(is_weak(asi_in0_data[IN_W-1-i*2*W-W -: W]));
        end
        weak_sum   = asi_in0_startofpacket ? 17'(weak_beat)
                                           : {1'b0, weak_acc_q} + 17'(weak_beat);
        weak_next  = weak_sum[16] ? 16'hFFFF : weak_sum[15:0];
        weak_acc_d = fwd ? weak_next : weak_acc_q;
        weak_out_d = (fwd && asi_in0_endofpacket) ? weak_next : weak_out_q;
    end

    assign status_weak_count = weak_out_q;
`endif

    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            pkt_count_q <= '0;
            error_q     <= 1'b0;
`ifdef QAM_DEMOD_WEAK_CNT_EN
            weak_acc_q  <= '0;
            weak_out_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            pkt_count_q <= pkt_count_d;
            error_q     <= error_d;
`ifdef QAM_DEMOD_WEAK_CNT_EN
            weak_acc_q  <= weak_acc_d;
            weak_out_q  <= weak_out_d;
`endif
        end
    end

    assign asi_in0_ready          = in_ready;
    assign aso_out0_valid         = out_valid_q;
    assign aso_out0_data          = out_data_q;
    assign aso_out0_startofpacket = out_sop_q;
    assign aso_out0_endofpacket   = out_eop_q;
    assign status_pkt_count       = pkt_count_q;
    assign status_error           = error_q;

endmodule

// File: tb/tb_qam_demodulation.sv
// tb/tb_qam_demodulation.sv - Randomized scoreboard bench for qam_demodulation

module tb_qam_demodulation;

    localparam int W      = 8;
    localparam int PD     = 16;
    localparam int IN_W   = PD * 2 * W;
    localparam int OUT_W  = PD * 2;
    localparam int THRESH = 2**W / 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [IN_W-1:0]    in_data;
    logic               in_valid, in_ready, in_sop, in_eop;
    logic [OUT_W-1:0]   out_data;
    logic               out_valid, out_ready, out_sop, out_eop;
    logic [31:0]        pkt_count;
    logic               err;
`ifdef QAM_DEMOD_WEAK_CNT_EN
    logic [15:0]        weak_count;
`endif

    qam_demodulation dut (
        .clock_clk              (clk),
        .reset_reset            (rst),
        .asi_in0_data           (in_data),
        .asi_in0_valid          (in_valid),
        .asi_in0_ready          (in_ready),
        .asi_in0_startofpacket  (in_sop),
        .asi_in0_endofpacket    (in_eop),
        .aso_out0_data          (out_data),
        .aso_out0_valid         (out_valid),
        .aso_out0_ready         (out_ready),
        .aso_out0_startofpacket (out_sop),
        .aso_out0_endofpacket   (out_eop),
        .status_pkt_count       (pkt_count),
        .status_error           (err)
`ifdef QAM_DEMOD_WEAK_CNT_EN
        ,
        .status_weak_count      (weak_count)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             sop;
        logic             eop;
    } beat_t;

    beat_t       exp_q[$];
    bit          m_in_pkt;
    bit          m_err;
    int unsigned m_cnt;
    int          m_weak_acc;
    int          m_weak_out;

    function automatic logic [OUT_W-1:0] model_syms(input logic [IN_W-1:0] d);
        logic [OUT_W-1:0] r;
        int iv, qv;
        r = '0;
        for (int i = 0; i < PD; i++) begin
            iv = $signed(d[IN_W-1-i*2*W -: W]);
            qv = $signed(d[IN_W-1-i*2*W-W -: W]);
            r[OUT_W-1-2*i] = (qv < 0);
            r[OUT_W-2-2*i] = (iv < 0);
        end
        return r;
    endfunction

    function automatic int model_weak(input logic [IN_W-1:0] d);
        int n, v;
        n = 0;
        for (int c = 0; c < 2*PD; c++) begin
            v = $signed(d[IN_W-1-c*W -: W]);
            if (v < 0) v = -v;
            if (v < THRESH) n++;
        end
        return n;
    endfunction

    function automatic logic [IN_W-1:0] rand_data();
        logic [IN_W-1:0] d;
        for (int k = 0; k < IN_W/32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [IN_W-1:0] lane_data(input int lane, input logic [IN_W-1:0] d,
                                                  input logic [W-1:0] iv, input logic [W-1:0] qv);
        logic [IN_W-1:0] r;
        r = d;
        r[IN_W-1-lane*2*W -: 2*W] = {iv, qv};
        return r;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_in_pkt   = 0;
        m_err      = 0;
        m_cnt      = 0;
        m_weak_acc = 0;
        m_weak_out = 0;
    endtask

    // One clock: check the state left by the previous edge, drive this cycle's
    // inputs, and advance the scoreboard for the coming edge.
    task automatic cycle(input bit iv, input logic [IN_W-1:0] d, input bit s, input bit e,
                         input bit ordy, output bit rdy_seen);
        bit    exp_rdy, acc;
        beat_t b;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== (exp_q.size() > 0)) begin
            fails++;
            $display("FAIL sb_valid: got %0b want %0b", out_valid, exp_q.size() > 0);
        end
        if (exp_q.size() > 0) begin
            tests++;
            if ({out_data, out_sop, out_eop} !== {exp_q[0].data, exp_q[0].sop, exp_q[0].eop}) begin
                fails++;
                $display("FAIL sb_beat: got %h/%0b/%0b want %h/%0b/%0b", out_data, out_sop, out_eop,
                         exp_q[0].data, exp_q[0].sop, exp_q[0].eop);
            end
        end
        tests++;
        if (pkt_count !== m_cnt) begin
            fails++;
            $display("FAIL sb_pkt_count: got %0d want %0d", pkt_count, m_cnt);
        end
        tests++;
        if (err !== m_err) begin
            fails++;
            $display("FAIL sb_error: got %0b want %0b", err, m_err);
        end
`ifdef QAM_DEMOD_WEAK_CNT_EN
        tests++;
        if (weak_count !== 16'(m_weak_out)) begin
            fails++;
            $display("FAIL sb_weak: got %0d want %0d", weak_count, m_weak_out);
        end
`endif
        in_valid  = iv;
        in_data   = d;
        in_sop    = s;
        in_eop    = e;
        out_ready = ordy;
        #1;
        rdy_seen = in_ready;
        exp_rdy  = (exp_q.size() == 0) || ordy;
        tests++;
        if (in_ready !== exp_rdy) begin
            fails++;
            $display("FAIL sb_ready: got %0b want %0b", in_ready, exp_rdy);
        end
        acc = iv && exp_rdy;
        if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
        if (acc) begin
            if (!m_in_pkt && !s) begin
                m_err = 1;
            end else begin
                if (m_in_pkt && s) m_err = 1;
                b.data = model_syms(d);
                b.sop  = s;
                b.eop  = e;
                exp_q.push_back(b);
                m_weak_acc = (s ? 0 : m_weak_acc) + model_weak(d);
                if (m_weak_acc > 65535) m_weak_acc = 65535;
                if (e) begin
                    m_cnt++;
                    m_weak_out = m_weak_acc;
                    m_in_pkt   = 0;
                end else begin
                    m_in_pkt = 1;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst       = 1;
        in_valid  = 0;
        in_data   = '0;
        in_sop    = 0;
        in_eop    = 0;
        out_ready = 1;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        in_valid = 0; in_data = '0; in_sop = 0; in_eop = 0; out_ready = 1;
        model_clear();
        @(posedge clk); #1;
        tests++;
        if ({out_valid, out_sop, out_eop, err, pkt_count, out_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v%0b s%0b e%0b err%0b cnt%0d d%h want all 0",
                     out_valid, out_sop, out_eop, err, pkt_count, out_data);
        end
        @(posedge clk); #1 rst = 0;
    endtask

    task automatic test_mapping();
        logic [IN_W-1:0] d;
        bit r;
        logic [W-1:0] pi [4] = '{8'h40, 8'hC0, 8'hC0, 8'h40};
        logic [W-1:0] pq [4] = '{8'h40, 8'h40, 8'hC0, 8'hC0};
        logic [W-1:0] xi [3] = '{8'h00, 8'h7F, 8'h80};
        logic [W-1:0] xq [3] = '{8'h80, 8'h00, 8'h7F};
        do_reset();
        d = '0;
        for (int i = 0; i < PD; i++) d = lane_data(i, d, pi[i%4], pq[i%4]);
        cycle(1, d, 1, 1, 1, r);
        cycle(0, '0, 0, 0, 1, r);
        tests++;
        if ({out_valid, out_sop, out_eop, out_data} !== {3'b111, 32'h1E1E1E1E}) begin
            fails++;
            $display("FAIL map_quadrants: got v%0b s%0b e%0b %h want 1/1/1 1e1e1e1e",
                     out_valid, out_sop, out_eop, out_data);
        end
        tests++;
        if (pkt_count !== 32'd1 || err !== 1'b0) begin
            fails++;
            $display("FAIL map_status: got cnt %0d err %0b want 1 0", pkt_count, err);
        end
        d = '0;
        for (int i = 0; i < PD; i++) d = lane_data(i, d, xi[i%3], xq[i%3]);
        cycle(1, d, 1, 1, 1, r);
        cycle(0, '0, 0, 0, 1, r);
        tests++;
        if (out_data !== 32'h86186186) begin
            fails++;
            $display("FAIL map_extremes: got %h want 86186186", out_data);
        end
        cycle(0, '0, 0, 0, 1, r);
    endtask

    task automatic test_stall();
        logic [OUT_W-1:0] held;
        logic [31:0]      base;
        bit r;
        base = pkt_count;
        cycle(1, rand_data(), 1, 0, 1, r);
        cycle(1, rand_data(), 0, 0, 1, r);
        begin
            logic [IN_W-1:0] d2;
            d2 = rand_data();
            for (int k = 0; k < 3; k++) begin
                cycle(1, d2, 0, 0, 0, r);
                if (k == 0) held = out_data;
                tests++;
                if (r !== 1'b0 || out_data !== held || out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL stall_hold: got rdy %0b v %0b d %h want rdy 0 v 1 d %h",
                             r, out_valid, out_data, held);
                end
            end
            cycle(1, d2, 0, 0, 1, r);
        end
        cycle(1, rand_data(), 0, 1, 1, r);
        cycle(0, '0, 0, 0, 1, r);
        cycle(0, '0, 0, 0, 1, r);
        tests++;
        if (pkt_count !== base + 32'd1) begin
            fails++;
            $display("FAIL stall_count: got %0d want %0d", pkt_count, base + 32'd1);
        end
    endtask

    task automatic test_missing_sop();
        bit r;
        do_reset();
        cycle(1, rand_data(), 0, 0, 1, r);
        cycle(0, '0, 0, 0, 1, r);
        tests++;
        if (out_valid !== 1'b0 || err !== 1'b1) begin
            fails++;
            $display("FAIL nosop_drop: got v %0b err %0b want v 0 err 1", out_valid, err);
        end
        cycle(1, rand_data(), 1, 0, 1, r);
        cycle(1, rand_data(), 0, 1, 1, r);
        cycle(0, '0, 0, 0, 1, r);
        cycle(0, '0, 0, 0, 1, r);
        tests++;
        if (pkt_count !== 32'd1) begin
            fails++;
            $display("FAIL nosop_recover: got cnt %0d want 1", pkt_count);
        end
    endtask

    task automatic test_sop_inside();
        bit r;
        do_reset();
        cycle(1, rand_data(), 1, 0, 1, r);
        cycle(1, rand_data(), 0, 0, 1, r);
        cycle(1, rand_data(), 1, 0, 1, r);
        cycle(1, rand_data(), 0, 0, 1, r);
        tests++;
        if (err !== 1'b1 || out_sop !== 1'b1 || pkt_count !== 32'd0) begin
            fails++;
            $display("FAIL sop_inside_restart: got err %0b sop %0b cnt %0d want 1 1 0",
                     err, out_sop, pkt_count);
        end
        cycle(1, rand_data(), 0, 1, 1, r);
        cycle(0, '0, 0, 0, 1, r);
        tests++;
        if (pkt_count !== 32'd1 || out_eop !== 1'b1) begin
            fails++;
            $display("FAIL sop_inside_count: got cnt %0d eop %0b want 1 1", pkt_count, out_eop);
        end
        cycle(0, '0, 0, 0, 1, r);
    endtask

    task automatic test_async_reset();
        bit r;
        do_reset();
        cycle(1, rand_data(), 1, 0, 1, r);
        cycle(0, '0, 0, 0, 0, r);
        #2 rst = 1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || pkt_count !== 32'd0 || err !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got v %0b cnt %0d err %0b want 0 0 0", out_valid, pkt_count, err);
        end
        model_clear();
        out_ready = 1;
        @(posedge clk); #1 rst = 0;
        cycle(1, rand_data(), 0, 0, 1, r);
        cycle(0, '0, 0, 0, 1, r);
        tests++;
        if (out_valid !== 1'b0 || err !== 1'b1) begin
            fails++;
            $display("FAIL async_reset_idle: got v %0b err %0b want 0 1", out_valid, err);
        end
        cycle(0, '0, 0, 0, 1, r);
    endtask

    task automatic test_random();
        bit r;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 3) != 0, rand_data(), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) < 7, r);
        end
        repeat (3) cycle(0, '0, 0, 0, 1, r);
    endtask

`ifdef QAM_DEMOD_WEAK_CNT_EN
    task automatic test_weak();
        logic [IN_W-1:0] d;
        bit r;
        do_reset();
        d = '0;
        for (int c = 0; c < 2*PD; c++) d[IN_W-1-c*W -: W] = (c == 0 || c == 5 || c == 31) ? 8'h05 : 8'h40;
        cycle(1, d, 1, 1, 1, r);
        cycle(0, '0, 0, 0, 1, r);
        tests++;
        if (weak_count !== 16'd3) begin
            fails++;
            $display("FAIL weak_count: got %0d want 3", weak_count);
        end
        cycle(0, '0, 0, 0, 1, r);
    endtask
`endif

    initial begin
        test_reset();
        test_mapping();
        test_stall();
        test_missing_sop();
        test_sop_inside();
        test_async_reset();
        test_random();
`ifdef QAM_DEMOD_WEAK_CNT_EN
        test_weak();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
